pwl_gen_mc: RTL and testbench
=============================

# pwl_gen_mc

Parametrised piecewise-linear (PWL) waveform generator for the RFSoC DAC datapath. It emits `SPC` samples per clock on a valid/ready stream. Segments (start, slope, length) are queued through an input handshake into an internal FIFO and played back-to-back with no bubbles. It sits between the PS-side segment loader and the DAC sample stream.

## Interface
- `SAMPLE_W`, 16: output sample width, two's complement.
- `SPC`, 16: samples per clock (beat).
- `SLOPE_W`, 24: signed slope width, per-sample increment.
- `FRAC_W`, 8: fractional bits of slope and accumulator.
- `LEN_W`, 16: segment length field, in beats.
- `DEPTH`, 8: segment FIFO depth, power of 2.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `seg_data`, in, `SAMPLE_W+SLOPE_W+LEN_W`: the fields are {start, slope, len}, with start in the MSBs.
- `seg_last`, in, 1: the segment is the final one of a waveform.
- `seg_valid`, in, 1 / `seg_ready`, out, 1: segment handshake.
- `run`, in, 1: pulse that starts playback.
- `halt`, in, 1: pulse that aborts playback and flushes the FIFO.
- `out_data`, out, `SPC*SAMPLE_W`: output beat, with sample 0 in the LSBs.
- `out_valid`, out, 1 / `out_ready`, in, 1: output handshake.
- `busy`, out, 1: high when the state is not IDLE.
- `underflow`, out, 1: sticky flag, cleared by `run` or reset.

## Operation
- **Segment FIFO**
  - First-word-fall-through.
  - `seg_ready` = not full.
  - A write occurs on `seg_valid && seg_ready`.
- **Accumulator** `acc`, signed, `SAMPLE_W+FRAC_W+1` bits.
  - On a segment load: `acc = start << FRAC_W`.
  - Sample i of a beat = `(acc + slope*i) >>> FRAC_W`, for i = 0..SPC-1.
  - On each accepted beat: `acc += slope*SPC`.
- **States: IDLE, LOAD, PLAY, STALL**
  - IDLE:
    - `out_valid`=0.
    - `run` with FIFO non-empty → LOAD.
    - `run` with FIFO empty → stay in IDLE and set `underflow`.
  - LOAD: pop the head segment, initialise `acc` and the beat counter (`len`), → PLAY.
  - PLAY, per beat:
    - `out_valid`=1 and `out_data` is registered.
    - On an accepted beat the counter decrements.
    - On the accepted final beat:
      - If the segment was `seg_last` → IDLE.
      - Else, if the FIFO is non-empty, load the head segment in the same cycle (zero bubble) and stay in PLAY.
      - Else → STALL and set `underflow`.
  - STALL:
    - `out_valid`=0.
    - When the FIFO becomes non-empty → LOAD.
- **Zero-length segments:** `len`=0 segments are consumed and produce no beats. A zero-length `seg_last` segment → IDLE.
- **`halt`** in any state:
  - Next state is IDLE, `out_valid`=0, FIFO flushed.
  - A segment write in the same cycle is discarded.
  - `halt` has priority over `run`.
- **Backpressure:** while `out_valid && !out_ready`, `out_data`, `acc` and the counter hold.
- **Overflow:** without the macro, samples wrap modulo 2^SAMPLE_W.

## Timing
- **Reset values:**
  - `out_data`=0, `out_valid`=0, `busy`=0, `underflow`=0.
  - `seg_ready`=1.
  - State IDLE, FIFO empty, `acc`=0.
- **Latency:** `run` in cycle N, with the FIFO non-empty → LOAD in N+1 → first beat valid in N+2.
- **Throughput:** one beat per clock while `out_ready`=1, including across segment boundaries.
- **Reset mid-playback:** all state clears immediately, asynchronously. De-assertion is synchronised internally to avoid recovery violations.
- **FIFO push and pop in the same cycle** when full: permitted. `seg_ready` is based on the registered full flag, so no write occurs that cycle.

## Configuration
- `PWL_SATURATE_EN`
  - Defined: each sample clamps to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Undefined: two's-complement wrap.
  - The accumulator itself never saturates in either mode.

## Structure
- Package `pwl_pkg`:
  - `pwl_seg_t` packed struct {start, slope, len}.
  - `pwl_state_e` enum.
  - Default width constants.
- Sub-module `pwl_seg_fifo`: FWFT FIFO with parameters `WIDTH`/`DEPTH` and ports `flush`, `full`, `empty`.
- Top level: FSM, accumulator, SPC-wide sample expansion (generate loop).

## Test plan
- **Ramp.** Setup: SPC=4, FRAC_W=8; segment start=0, slope=0x100, len=2, last.
  - Beats {0,1,2,3} then {4,5,6,7}.
  - Then IDLE.
- **Back-to-back.** Segments (start=10, slope=0, len=1) and (start=-5, slope=-0x100, len=1, last).
  - Beats {10,10,10,10} then {-5,-6,-7,-8} in consecutive cycles, with no bubble.
- **Underflow.** One non-last segment, len=1.
  - After its beat the state is STALL, `out_valid`=0 and `underflow`=1.
  - Pushing the next segment resumes output.
- **Backpressure.** Toggle `out_ready` randomly 50% during a len=8 ramp.
  - The accepted beat sequence is identical to the constant-ready run.
  - Exactly 8 beats are accepted.
- **Overflow.** Start=32767, slope=0x100, SAMPLE_W=16.
  - With `PWL_SATURATE_EN`: samples stay at 32767.
  - Without it: the second sample is -32768.
- **Halt.** Assert `halt` mid-segment with 3 segments queued.
  - Next cycle: `out_valid`=0, `busy`=0, FIFO empty.
  - A subsequent `run` sets `underflow`.

Source files
------------

// File: rtl/pwl_pkg.sv
// Shared types and default widths for the piecewise-linear waveform generator.
package pwl_pkg;

  localparam int PWL_SAMPLE_W = 16;
  localparam int PWL_SPC      = 16;
  localparam int PWL_SLOPE_W  = 24;
  localparam int PWL_FRAC_W   = 8;
  localparam int PWL_LEN_W    = 16;
  localparam int PWL_DEPTH    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PLAY  = 2'd2,
    STALL = 2'd3
  } pwl_state_e;

  // Segment word as presented on seg_data, start in the MSBs.
  typedef struct packed {
    logic [PWL_SAMPLE_W-1:0] start;
    logic [PWL_SLOPE_W-1:0]  slope;
    logic [PWL_LEN_W-1:0]    len;
  } pwl_seg_t;

endpackage

// File: rtl/pwl_seg_fifo.sv
// First-word-fall-through segment FIFO; full/empty come straight from registered
// pointers, and flush empties it in one cycle.
module pwl_seg_fifo #(
  parameter int WIDTH = 57,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign dout  = mem[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/pwl_gen_mc.sv
// Multi-sample-per-clock PWL generator: segment FIFO, playback FSM and SPC-lane
// expansion. Define PWL_SATURATE_EN to clamp samples instead of wrapping.
module pwl_gen_mc
  import pwl_pkg::*;
#(
  parameter int SAMPLE_W = PWL_SAMPLE_W,
  parameter int SPC      = PWL_SPC,
  parameter int SLOPE_W  = PWL_SLOPE_W,
  parameter int FRAC_W   = PWL_FRAC_W,
  parameter int LEN_W    = PWL_LEN_W,
  parameter int DEPTH    = PWL_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SAMPLE_W+SLOPE_W+LEN_W-1:0] seg_data,
  input  logic                          seg_last,
  input  logic                          seg_valid,
  output logic                          seg_ready,
  input  logic                          run,
  input  logic                          halt,
  output logic [SPC*SAMPLE_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          underflow,
  output pwl_state_e                    dbg_state
);

  localparam int SEG_W = SAMPLE_W + SLOPE_W + LEN_W;
  localparam int AW    = SAMPLE_W + FRAC_W + 1;
  localparam int EW    = ((AW > SLOPE_W) ? AW : SLOPE_W) + $clog2(SPC) + 2;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // a source never drops valid or changes data while waiting for ready.

  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [SEG_W:0]             fifo_dout;
  logic                       head_last;
  logic [SAMPLE_W-1:0]        head_start;
  logic signed [SLOPE_W-1:0]  head_slope;
  logic [LEN_W-1:0]           head_len;

  assign seg_ready = !fifo_full;
  assign fifo_push = seg_valid && seg_ready && !halt;
  assign {head_last, head_start, head_slope, head_len} = fifo_dout;

  pwl_seg_fifo #(.WIDTH(SEG_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_i),
    .flush (halt),
    .push  (fifo_push),
    .din   ({seg_last, seg_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  pwl_state_e                state, state_nxt;
  logic signed [AW-1:0]      acc;
  logic signed [SLOPE_W-1:0] slope_q;
  logic [LEN_W-1:0]          cnt;
  logic                      last_q;
  logic [SPC*SAMPLE_W-1:0]   out_q;
  logic                      uf_q;
  logic                      consume, do_load, do_adv, set_uf;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    consume   = 1'b0;
    fifo_pop  = 1'b0;
    do_load   = 1'b0;
    do_adv    = 1'b0;
    set_uf    = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          if (!fifo_empty) state_nxt = LOAD;
          else             set_uf    = 1'b1;
        end
      end
      LOAD: consume = 1'b1;
      PLAY: begin
        if (out_ready) begin
          if (cnt == LEN_W'(1)) begin
            if (last_q)           state_nxt = IDLE;
            else if (!fifo_empty) consume   = 1'b1;
            else begin
              state_nxt = STALL;
              set_uf    = 1'b1;
            end
          end else begin
            do_adv = 1'b1;
          end
        end
      end
      STALL: if (!fifo_empty) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
    // Taking the head segment: zero-length ones emit nothing and fall through.
    if (consume) begin
      fifo_pop = 1'b1;
      if (head_len == '0) begin
        state_nxt = head_last ? IDLE : STALL;
      end else begin
        do_load   = 1'b1;
        state_nxt = PLAY;
      end
    end
    if (halt) begin
      state_nxt = IDLE;
      fifo_pop  = 1'b0;
      do_load   = 1'b0;
      do_adv    = 1'b0;
      set_uf    = 1'b0;
    end
  end

  // acc always holds the sample-0 value of the beat currently on out_data.
  logic signed [AW-1:0]      start_sh, acc_step, exp_base;
  logic signed [SLOPE_W-1:0] exp_slope;
  logic [SPC-1:0][SAMPLE_W-1:0] lane_d;

  assign start_sh  = {head_start[SAMPLE_W-1], head_start, {FRAC_W{1'b0}}};
  assign acc_step  = AW'(EW'(acc) + EW'(slope_q) * EW'(SPC));
  assign exp_base  = do_load ? start_sh : acc_step;
  assign exp_slope = do_load ? head_slope : slope_q;

`ifdef PWL_SATURATE_EN
  localparam logic signed [EW-1:0] SMAX = EW'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [EW-1:0] SMIN = -SMAX - EW'(1);
`endif

  for (genvar i = 0; i < SPC; i++) begin : g_lane
    localparam logic signed [EW-1:0] IDX = EW'(i);
    logic signed [EW-1:0] sum;
    assign sum = EW'(exp_base) + EW'(exp_slope) * IDX;
`ifdef PWL_SATURATE_EN
    logic signed [EW-1:0] sh;
    assign sh = sum >>> FRAC_W;
    assign lane_d[i] = (sh > SMAX) ? SAMPLE_W'(SMAX) :
                       (sh < SMIN) ? SAMPLE_W'(SMIN) : sh[SAMPLE_W-1:0];
`else
    assign lane_d[i] = SAMPLE_W'(sum >>> FRAC_W);
`endif
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      acc     <= '0;
      slope_q <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
      out_q   <= '0;
    end else if (do_load) begin
      acc     <= exp_base;
      slope_q <= head_slope;
      cnt     <= head_len;
      last_q  <= head_last;
      out_q   <= lane_d;
    end else if (do_adv) begin
      acc     <= exp_base;
      cnt     <= cnt - LEN_W'(1);
      out_q   <= lane_d;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i)              uf_q <= 1'b0;
    else if (set_uf)         uf_q <= 1'b1;
    else if (run && !halt)   uf_q <= 1'b0;
  end

  assign out_data  = out_q;
  assign out_valid = (state == PLAY);
  assign busy      = (state != IDLE);
  assign underflow = uf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_pwl_gen_mc.sv
// Self-checking bench for pwl_gen_mc (SPC=4): scoreboard of expected beats
// built from an arithmetic model, checked on every accepted output beat.
module tb_pwl_gen_mc;
  import pwl_pkg::*;

  localparam int SAMPLE_W = 16;
  localparam int SPC      = 4;
  localparam int SLOPE_W  = 24;
  localparam int FRAC_W   = 8;
  localparam int LEN_W    = 16;
  localparam int DEPTH    = 8;
  localparam int BW       = SPC * SAMPLE_W;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic [SAMPLE_W+SLOPE_W+LEN_W-1:0] seg_data;
  logic                              seg_last, seg_valid, seg_ready;
  logic                              run, halt;
  logic [BW-1:0]                     out_data;
  logic                              out_valid;
  logic                              out_ready = 1'b1;
  logic                              busy, underflow;
  pwl_state_e                        dbg_state;

  pwl_gen_mc #(
    .SAMPLE_W(SAMPLE_W), .SPC(SPC), .SLOPE_W(SLOPE_W),
    .FRAC_W(FRAC_W), .LEN_W(LEN_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_data(seg_data), .seg_last(seg_last),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .run(run), .halt(halt),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .underflow(underflow), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got still_running expected finished");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [BW-1:0] exp_q[$];
  int            beats_acc = 0;
  logic [BW-1:0] last_beat = '0;
  logic [BW-1:0] held      = '0;
  bit            hold_pend = 1'b0;
  bit            rnd_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] model_beat(input int start, input int slope, input int k);
    logic [BW-1:0] r;
    longint        a, s;
    logic [63:0]   sv;
    r = '0;
    for (int i = 0; i < SPC; i++) begin
      a = (longint'(start) <<< FRAC_W) + longint'(slope) * longint'(k * SPC + i);
      s = a >>> FRAC_W;
`ifdef PWL_SATURATE_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`endif
      sv = 64'(s);
      r[i*SAMPLE_W +: SAMPLE_W] = sv[SAMPLE_W-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend && out_valid) check_eq("bp_hold", out_data, held);
      hold_pend = out_valid && !out_ready;
      held      = out_data;
      if (out_valid && out_ready) begin
        check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check_eq("beat_data", out_data, exp_q.pop_front());
        last_beat = out_data;
        beats_acc++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Driver tasks
  task automatic push_seg(input int start, input int slope, input int len, input bit last,
                          input bit expect_out);
    pwl_seg_t s;
    if (expect_out)
      for (int k = 0; k < len; k++) exp_q.push_back(model_beat(start, slope, k));
    s.start   = 16'(start);
    s.slope   = 24'(slope);
    s.len     = 16'(len);
    seg_data  = s;
    seg_last  = last;
    seg_valid = 1'b1;
    for (int t = 0; t < 100 && !seg_ready; t++) begin
      @(posedge clk); #1;
    end
    check_eq("push_ready", seg_ready, 1'b1);
    @(posedge clk); #1;
    seg_valid = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 500 && busy; t++) begin
      @(posedge clk); #1;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  int            b0;
  logic [BW-1:0] ramp_last;
  logic [15:0]   ovf_s0, ovf_s1;

  initial begin
    rst_n = 1'b0; seg_data = '0; seg_last = 1'b0; seg_valid = 1'b0;
    run = 1'b0; halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_underflow", underflow, 1'b0);
    check_eq("rst_seg_ready", seg_ready, 1'b1);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Ramp with latency check
    b0 = beats_acc;
    push_seg(0, 'h100, 2, 1'b1, 1'b1);
    pulse_run();
    @(negedge clk);
    check_eq("lat_load_state", 64'(dbg_state), 64'(LOAD));
    check_eq("lat_load_valid", out_valid, 1'b0);
    @(negedge clk);
    check_eq("lat_first_valid", out_valid, 1'b1);
    wait_idle("ramp_idle");
    check_eq("ramp_beats", 64'(beats_acc - b0), 64'd2);
    ramp_last = {16'd7, 16'd6, 16'd5, 16'd4};
    check_eq("ramp_last", last_beat, ramp_last);

    // Back-to-back segments, no bubble
    b0 = beats_acc;
    push_seg(10, 0, 1, 1'b0, 1'b1);
    push_seg(-5, -'h100, 1, 1'b1, 1'b1);
    pulse_run();
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    check_eq("b2b_first", out_valid, 1'b1);
    @(negedge clk);
    check_eq("b2b_no_bubble", out_valid, 1'b1);
    wait_idle("b2b_idle");
    check_eq("b2b_beats", 64'(beats_acc - b0), 64'd2);

    // Underflow into STALL, then resume
    b0 = beats_acc;
    push_seg(100, 'h80, 1, 1'b0, 1'b1);
    pulse_run();
    for (int t = 0; t < 20 && dbg_state != STALL; t++) @(negedge clk);
    check_eq("uf_state", 64'(dbg_state), 64'(STALL));
    check_eq("uf_valid", out_valid, 1'b0);
    check_eq("uf_flag", underflow, 1'b1);
    push_seg(200, 0, 1, 1'b1, 1'b1);
    wait_idle("uf_idle");
    check_eq("uf_sticky", underflow, 1'b1);
    check_eq("uf_beats", 64'(beats_acc - b0), 64'd2);

    // Zero-length segments
    b0 = beats_acc;
    push_seg(7, 0, 0, 1'b0, 1'b1);
    push_seg(3, 0, 1, 1'b1, 1'b1);
    pulse_run();
    wait_idle("zl_idle");
    check_eq("zl_beats", 64'(beats_acc - b0), 64'd1);
    check_eq("uf_cleared_by_run", underflow, 1'b0);
    b0 = beats_acc;
    push_seg(0, 0, 0, 1'b1, 1'b1);
    pulse_run();
    wait_idle("zl_last_idle");
    check_eq("zl_last_beats", 64'(beats_acc - b0), 64'd0);

    // Random backpressure
    b0 = beats_acc;
    rnd_ready = 1'b1;
    push_seg(0, 'h100, 8, 1'b1, 1'b1);
    pulse_run();
    wait_idle("bp_idle");
    rnd_ready = 1'b0;
    check_eq("bp_beats", 64'(beats_acc - b0), 64'd8);

    // Overflow at the positive rail
    push_seg(32767, 'h100, 1, 1'b1, 1'b1);
    pulse_run();
    wait_idle("ovf_idle");
    ovf_s0 = last_beat[15:0];
    ovf_s1 = last_beat[31:16];
    check_eq("ovf_s0", ovf_s0, 16'h7fff);
`ifdef PWL_SATURATE_EN
    check_eq("ovf_s1", ovf_s1, 16'h7fff);
`else
    check_eq("ovf_s1", ovf_s1, 16'h8000);
`endif
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    // Halt mid-segment with a simultaneous write
    b0 = beats_acc;
    push_seg(0, 'h100, 4, 1'b0, 1'b1);
    push_seg(50, 0, 4, 1'b0, 1'b0);
    push_seg(60, 0, 4, 1'b1, 1'b0);
    pulse_run();
    for (int t = 0; t < 50 && (beats_acc - b0) < 2; t++) begin
      @(posedge clk); #1;
    end
    check_eq("halt_mid_segment", out_valid, 1'b1);
    halt = 1'b1;
    seg_data = '1; seg_last = 1'b1; seg_valid = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0; seg_valid = 1'b0;
    check_eq("halt_valid", out_valid, 1'b0);
    check_eq("halt_busy", busy, 1'b0);
    check_eq("halt_seg_ready", seg_ready, 1'b1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    pulse_run();
    @(negedge clk);
    check_eq("halt_run_underflow", underflow, 1'b1);
    check_eq("halt_run_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
